// File: rtl/exe_hazard_ctrl.sv
// Execute-stage pipeline control: operand forwarding selects, load-use and RAW stalls,
// branch flush sequencing and the SRAM request/freeze handshake with a sticky timeout flag.
module exe_hazard_ctrl #(
  parameter bit         FWD_EN  = 1'b1,
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_two_src,
  input  logic       id_use_src1,
  input  logic [3:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic       exe_branch,
  input  logic [3:0] mem_dest,
  input  logic       mem_wb_en,
  input  logic       mem_r_en,
  input  logic       mem_w_en,
  input  logic [3:0] wb_dest,
  input  logic       wb_wb_en,
  input  logic       sram_ack,
  output logic [1:0] sel_src1,
  output logic [1:0] sel_src2,
  output logic       hazard_stall,
  output logic       flush,
  output logic       mem_freeze,
  output logic       sram_req,
  output logic       sram_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic       r_err;
  logic       w_err_next;
  logic       r_flush;
  logic       w_flush_next;
  logic       r_ack_early;
  logic       w_ack_early_next;

  logic       w_req;
  logic       w_freeze;
  logic       w_flush;
  logic       w_hazard;
  logic       w_stall;

  logic [3:0] w_src     [2];
  logic [1:0] w_rd;
  logic [1:0] w_exe_hit;
  logic [1:0] w_mem_hit;
  logic [1:0] w_sel     [2];

  // The WB stage is resolved by the register file write-through, so it never forwards here.
  logic w_wb_unused;
  assign w_wb_unused = ^{wb_dest, wb_wb_en};

  assign w_src[0] = id_src1;
  assign w_src[1] = id_src2;
  assign w_rd     = {id_two_src, id_use_src1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      assign w_exe_hit[gi] = w_rd[gi] & exe_wb_en & (exe_dest == w_src[gi]);
      assign w_mem_hit[gi] = w_rd[gi] & mem_wb_en & (mem_dest == w_src[gi]);

      // A load in EXE has no data yet; that operand falls through to the MEM check.
      always_comb begin
        w_sel[gi] = 2'd0;
        if (FWD_EN) begin
          if (w_exe_hit[gi] && !exe_mem_r_en) begin
            w_sel[gi] = 2'd1;
          end else if (w_mem_hit[gi]) begin
            w_sel[gi] = 2'd2;
          end
        end
      end
    end
  endgenerate

  always_comb begin
    if (FWD_EN) begin
      w_hazard = exe_mem_r_en & (|w_exe_hit);
    end else begin
      w_hazard = (|w_exe_hit) | (|w_mem_hit);
    end
  end

  assign w_flush      = exe_branch | r_flush;
  assign w_stall      = w_hazard & ~w_flush;
  assign w_flush_next = w_flush & w_freeze;

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_err_next       = r_err;
    w_ack_early_next = r_ack_early;
    w_req            = 1'b0;
    w_freeze         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_r_en || mem_w_en) begin
          w_req            = 1'b1;
          w_freeze         = 1'b1;
          w_cnt_next       = 4'd0;
          w_ack_early_next = sram_ack;
          w_state_next     = S_WAIT;
        end
      end
      S_WAIT: begin
        w_freeze = 1'b1;
        if (r_cnt != TIMEOUT) begin
          w_cnt_next = r_cnt + 4'd1;
        end
        // Timeout fires as the counter reaches TIMEOUT, i.e. after exactly TIMEOUT wait cycles.
        if (sram_ack || r_ack_early) begin
          w_ack_early_next = 1'b0;
          w_state_next     = S_DONE;
        end else if (r_cnt >= (TIMEOUT - 4'd1)) begin
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_err       <= 1'b0;
      r_flush     <= 1'b0;
      r_ack_early <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_err       <= w_err_next;
      r_flush     <= w_flush_next;
      r_ack_early <= w_ack_early_next;
    end
  end

  // Reset forces every output low, including the purely combinational ones.
  assign sel_src1     = {2{rst}} & w_sel[0];
  assign sel_src2     = {2{rst}} & w_sel[1];
  assign hazard_stall = rst & w_stall;
  assign flush        = rst & w_flush;
  assign mem_freeze   = rst & w_freeze;
  assign sram_req     = rst & w_req;
  assign sram_err     = rst & r_err;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed bench for exe_hazard_ctrl: expected outputs are queued per step and
// compared against the DUT on the falling edge of each cycle.
module tb_exe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic       id_use_src1;
  logic [3:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic       exe_branch;
  logic [3:0] mem_dest;
  logic       mem_wb_en;
  logic       mem_r_en;
  logic       mem_w_en;
  logic [3:0] wb_dest;
  logic       wb_wb_en;
  logic       sram_ack;
  logic [1:0] sel_src1;
  logic [1:0] sel_src2;
  logic       hazard_stall;
  logic       flush;
  logic       mem_freeze;
  logic       sram_req;
  logic       sram_err;

  logic [1:0] nf_sel_src1;
  logic [1:0] nf_sel_src2;
  logic       nf_hazard_stall;
  logic       nf_flush_unused;
  logic       nf_freeze_unused;
  logic       nf_req_unused;
  logic       nf_err_unused;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       stall;
    logic       flush;
    logic       freeze;
    logic       req;
    logic       err;
  } exp_t;

  typedef struct {
    string      tag;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       stall;
  } nf_exp_t;

  exp_t    exp_q[$];
  nf_exp_t nf_q[$];

  exe_hazard_ctrl #(.FWD_EN(1'b1), .TIMEOUT(4'd15)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_use_src1(id_use_src1),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_branch(exe_branch),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .sram_ack(sram_ack),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .hazard_stall(hazard_stall), .flush(flush),
    .mem_freeze(mem_freeze), .sram_req(sram_req), .sram_err(sram_err)
  );

  exe_hazard_ctrl #(.FWD_EN(1'b0), .TIMEOUT(4'd15)) dut_nf (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src), .id_use_src1(id_use_src1),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_branch(exe_branch),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en), .sram_ack(sram_ack),
    .sel_src1(nf_sel_src1), .sel_src2(nf_sel_src2), .hazard_stall(nf_hazard_stall), .flush(nf_flush_unused),
    .mem_freeze(nf_freeze_unused), .sram_req(nf_req_unused), .sram_err(nf_err_unused)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input string fld, input logic [1:0] got, input logic [1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] s1, input logic [1:0] s2,
                            input logic stall, input logic fl, input logic frz,
                            input logic req, input logic err);
    exp_t e;
    e.tag = tag; e.s1 = s1; e.s2 = s2; e.stall = stall;
    e.flush = fl; e.freeze = frz; e.req = req; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic expect_nf(input string tag, input logic [1:0] s1, input logic [1:0] s2, input logic stall);
    nf_exp_t e;
    e.tag = tag; e.s1 = s1; e.s2 = s2; e.stall = stall;
    nf_q.push_back(e);
  endtask

  task automatic check_cycle();
    exp_t    e;
    nf_exp_t n;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.tag, "sel_src1", sel_src1, e.s1);
      cmp(e.tag, "sel_src2", sel_src2, e.s2);
      cmp(e.tag, "hazard_stall", {1'b0, hazard_stall}, {1'b0, e.stall});
      cmp(e.tag, "flush", {1'b0, flush}, {1'b0, e.flush});
      cmp(e.tag, "mem_freeze", {1'b0, mem_freeze}, {1'b0, e.freeze});
      cmp(e.tag, "sram_req", {1'b0, sram_req}, {1'b0, e.req});
      cmp(e.tag, "sram_err", {1'b0, sram_err}, {1'b0, e.err});
      $display("step %-16s sel1=%0d sel2=%0d stall=%0d flush=%0d frz=%0d req=%0d err=%0d",
               e.tag, sel_src1, sel_src2, hazard_stall, flush, mem_freeze, sram_req, sram_err);
    end
    while (nf_q.size() > 0) begin
      n = nf_q.pop_front();
      cmp(n.tag, "nf_sel_src1", nf_sel_src1, n.s1);
      cmp(n.tag, "nf_sel_src2", nf_sel_src2, n.s2);
      cmp(n.tag, "nf_hazard_stall", {1'b0, nf_hazard_stall}, {1'b0, n.stall});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0; id_use_src1 = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_branch = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    wb_dest = 4'd0; wb_wb_en = 1'b0; sram_ack = 1'b0;
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    exe_branch = 1'b1; mem_r_en = 1'b1; exe_dest = 4'd1; exe_wb_en = 1'b1;
    id_src1 = 4'd1; id_use_src1 = 1'b1; wb_wb_en = 1'b1;
    expect_out("reset", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();

    clear_in(); rst = 1'b1;
    expect_out("idle", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();

    // Forwarding
    exe_dest = 4'd1; exe_wb_en = 1'b1; id_src1 = 4'd1; id_use_src1 = 1'b1; id_src2 = 4'd2; id_two_src = 1'b1;
    expect_out("fwd_exe", 2'd1, 2'd0, 0, 0, 0, 0, 0);
    expect_nf("nf_exe", 2'd0, 2'd0, 1'b1);
    check_cycle();

    exe_dest = 4'd5; mem_dest = 4'd1; mem_wb_en = 1'b1;
    expect_out("fwd_mem", 2'd2, 2'd0, 0, 0, 0, 0, 0);
    expect_nf("nf_mem", 2'd0, 2'd0, 1'b1);
    check_cycle();

    exe_dest = 4'd1; mem_dest = 4'd1; id_src2 = 4'd1;
    expect_out("fwd_prio", 2'd1, 2'd1, 0, 0, 0, 0, 0);
    check_cycle();

    exe_dest = 4'd4; mem_dest = 4'd7; id_src1 = 4'd7; id_src2 = 4'd4;
    expect_out("fwd_indep", 2'd2, 2'd1, 0, 0, 0, 0, 0);
    check_cycle();

    exe_dest = 4'd1; mem_dest = 4'd2; id_src1 = 4'd1; id_use_src1 = 1'b0; id_src2 = 4'd2; id_two_src = 1'b0;
    expect_out("fwd_unread", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    expect_nf("nf_unread", 2'd0, 2'd0, 1'b0);
    check_cycle();

    clear_in();
    exe_dest = 4'd1; mem_dest = 4'd1; id_src1 = 4'd1; id_use_src1 = 1'b1;
    expect_out("fwd_no_wb", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();

    // Load-use
    clear_in();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
    id_src2 = 4'd3; id_two_src = 1'b1; id_src1 = 4'd0; id_use_src1 = 1'b1;
    expect_out("load_use", 2'd0, 2'd0, 1, 0, 0, 0, 0);
    check_cycle();

    clear_in();
    mem_dest = 4'd3; mem_wb_en = 1'b1; id_src2 = 4'd3; id_two_src = 1'b1; id_use_src1 = 1'b1;
    expect_out("load_adv", 2'd0, 2'd2, 0, 0, 0, 0, 0);
    check_cycle();

    clear_in();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
    id_src2 = 4'd3; id_two_src = 1'b0; id_src1 = 4'd5; id_use_src1 = 1'b1;
    expect_out("load_noread", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();

    exe_dest = 4'd6; id_src1 = 4'd6;
    expect_out("load_src1", 2'd0, 2'd0, 1, 0, 0, 0, 0);
    check_cycle();

    // Branch overrides stall
    exe_dest = 4'd3; id_src2 = 4'd3; id_two_src = 1'b1; id_src1 = 4'd0; exe_branch = 1'b1;
    expect_out("br_over_stall", 2'd0, 2'd0, 0, 1, 0, 0, 0);
    expect_nf("nf_br", 2'd0, 2'd0, 1'b0);
    check_cycle();

    exe_branch = 1'b0;
    expect_out("br_gone", 2'd0, 2'd0, 1, 0, 0, 0, 0);
    check_cycle();

    // SRAM load, ack on the 4th wait cycle, branch arriving mid-freeze
    clear_in();
    mem_r_en = 1'b1;
    expect_out("ld_req", 2'd0, 2'd0, 0, 0, 1, 1, 0);
    check_cycle();
    expect_out("ld_wait1", 2'd0, 2'd0, 0, 0, 1, 0, 0);
    check_cycle();
    expect_out("ld_wait2", 2'd0, 2'd0, 0, 0, 1, 0, 0);
    check_cycle();
    exe_branch = 1'b1;
    expect_out("ld_wait3_br", 2'd0, 2'd0, 0, 1, 1, 0, 0);
    check_cycle();
    exe_branch = 1'b0; sram_ack = 1'b1;
    expect_out("ld_wait4_ack", 2'd0, 2'd0, 0, 1, 1, 0, 0);
    check_cycle();
    expect_out("ld_done", 2'd0, 2'd0, 0, 1, 0, 0, 0);
    check_cycle();
    mem_r_en = 1'b0; sram_ack = 1'b0;
    expect_out("ld_idle", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();
    sram_ack = 1'b1;
    expect_out("stray_ack", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();
    sram_ack = 1'b0;
    expect_out("stray_after", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();

    // SRAM timeout
    mem_w_en = 1'b1;
    expect_out("to_req", 2'd0, 2'd0, 0, 0, 1, 1, 0);
    check_cycle();
    for (int i = 1; i <= 15; i++) begin
      expect_out($sformatf("to_wait%0d", i), 2'd0, 2'd0, 0, 0, 1, 0, 0);
      check_cycle();
    end
    expect_out("to_done", 2'd0, 2'd0, 0, 0, 0, 0, 1);
    check_cycle();
    mem_w_en = 1'b0;
    expect_out("to_idle", 2'd0, 2'd0, 0, 0, 0, 0, 1);
    check_cycle();
    expect_out("to_sticky", 2'd0, 2'd0, 0, 0, 0, 0, 1);
    check_cycle();

    // Reset in WAIT with a pending ack
    mem_r_en = 1'b1;
    expect_out("rw_req", 2'd0, 2'd0, 0, 0, 1, 1, 1);
    check_cycle();
    expect_out("rw_wait1", 2'd0, 2'd0, 0, 0, 1, 0, 1);
    check_cycle();
    rst = 1'b0; sram_ack = 1'b1;
    expect_out("rw_reset", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();
    rst = 1'b1; sram_ack = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b1;
    expect_out("rw_fresh_req", 2'd0, 2'd0, 0, 0, 1, 1, 0);
    check_cycle();
    sram_ack = 1'b1;
    expect_out("rw_wait1_ack", 2'd0, 2'd0, 0, 0, 1, 0, 0);
    check_cycle();
    sram_ack = 1'b0; mem_w_en = 1'b0;
    expect_out("rw_done", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();

    // Ack coincident with the request: two-cycle freeze
    mem_r_en = 1'b1; sram_ack = 1'b1;
    expect_out("fast_req_ack", 2'd0, 2'd0, 0, 0, 1, 1, 0);
    check_cycle();
    sram_ack = 1'b0;
    expect_out("fast_wait1", 2'd0, 2'd0, 0, 0, 1, 0, 0);
    check_cycle();
    mem_r_en = 1'b0;
    expect_out("fast_done", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();
    expect_out("fast_idle", 2'd0, 2'd0, 0, 0, 0, 0, 0);
    check_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
